muldiv_sequencer: RTL and testbench

//  Multi-cycle multiply/divide controller. Accepts one operation per valid/ready

---
 rtl/muldiv_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle multiply/divide controller.
// Takes one operation per valid/ready handshake. It runs a 1-bit-per-cycle
// shift-add (MUL) or restoring shift-subtract (DIV) engine on operand
// magnitudes, then applies a sign fix-up and writes the HI/LO result registers.
// Ports:
//   clock, clear_n             rising-edge clock, async active-low reset
//   start_valid / start_ready  request handshake (start_ready is combinational)
//   op                         00 MULS, 01 MULU, 10 DIVU, 11 DIVS
//   a, b                       operands, sampled only on accept
//   cancel                     aborts an operation in flight; blocks accept when idle
//   busy                       engine not idle
//   done                       one-cycle pulse when hi/lo/div_by_zero update
//   hi, lo                     MUL: product high/low; DIV: remainder/quotient
//   div_by_zero                last completed DIV had a zero divisor
module muldiv_sequencer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
   localparam logic [1:0] OP_MULS = 2'b00;
   localparam logic [1:0] OP_DIVS = 2'b11;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_t;

   state_t           state, state_n;
   logic [CW-1:0]    count;
   logic             accept_c, iter_c, commit_c;

   // Operation context captured at accept
   logic             is_div, b_zero, neg_q, neg_r;
   logic [WIDTH-1:0] a_raw, opnd_b;
   // Shared engine registers: MUL = partial product high / multiplier-low;
   // DIV = partial remainder / dividend-quotient
   logic [WIDTH-1:0] acc_hi, acc_lo;

   logic             signed_c, a_neg_c, b_neg_c;
   logic [WIDTH-1:0] a_mag_c, b_mag_c;
   logic [WIDTH-1:0] mul_add_c;
   logic [WIDTH:0]   mul_sum_c;
   logic [WIDTH:0]   div_shift_c;
   logic             div_ge_c;
   logic [WIDTH-1:0] div_diff_c;
   logic [2*WIDTH-1:0] prod_c;
   logic [WIDTH-1:0] res_hi_c, res_lo_c;

   assign start_ready = (state == ST_IDLE) && !cancel && clear_n;

   // Operand magnitudes for the unsigned engine
   assign signed_c = (op == OP_MULS) || (op == OP_DIVS);
   assign a_neg_c  = signed_c && a[WIDTH-1];
   assign b_neg_c  = signed_c && b[WIDTH-1];
   assign a_mag_c  = a_neg_c ? (~a + WIDTH'(1)) : a;
   assign b_mag_c  = b_neg_c ? (~b + WIDTH'(1)) : b;

   // One shift-add step: conditionally add, then shift the 2W pair right
   assign mul_add_c = acc_lo[0] ? opnd_b : '0;
   assign mul_sum_c = {1'b0, acc_hi} + {1'b0, mul_add_c};

   // One restoring step; remainder stays below divisor so W bits of difference suffice
   assign div_shift_c = {acc_hi, acc_lo[WIDTH-1]};
   assign div_ge_c    = div_shift_c >= {1'b0, opnd_b};
   assign div_diff_c  = div_shift_c[WIDTH-1:0] - opnd_b;

   // Sign fix-up of the final engine state
   assign prod_c = neg_q ? (~{acc_hi, acc_lo} + (2*WIDTH)'(1)) : {acc_hi, acc_lo};

   always_comb begin : fix_result
      res_hi_c = prod_c[2*WIDTH-1:WIDTH];
      res_lo_c = prod_c[WIDTH-1:0];
      if (is_div) begin
         if (b_zero) begin
            res_hi_c = a_raw;
            res_lo_c = '1;
         end else begin
            res_hi_c = neg_r ? (~acc_hi + WIDTH'(1)) : acc_hi;
            res_lo_c = neg_q ? (~acc_lo + WIDTH'(1)) : acc_lo;
         end
      end
   end

   // State register
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) state <= ST_IDLE;
      else          state <= state_n;
   end

   // Next state and step controls; cancel overrides both RUN and the FIX commit
   always_comb begin : fsm_next
      state_n  = state;
      accept_c = 1'b0;
      iter_c   = 1'b0;
      commit_c = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_valid && start_ready) begin
               accept_c = 1'b1;
               state_n  = ST_RUN;
            end
         end
         ST_RUN: begin
            if (cancel) begin
               state_n = ST_IDLE;
            end else begin
               iter_c = 1'b1;
               if (count == LAST_ITER) state_n = ST_FIX;
            end
         end
         ST_FIX: begin
            state_n  = ST_IDLE;
            commit_c = !cancel;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Engine datapath and registered outputs
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         count       <= '0;
         is_div      <= 1'b0;
         b_zero      <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         a_raw       <= '0;
         opnd_b      <= '0;
         acc_hi      <= '0;
         acc_lo      <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         div_by_zero <= 1'b0;
      end else begin
         busy <= (state_n != ST_IDLE);
         done <= commit_c;
         if (accept_c) begin
            count  <= '0;
            is_div <= op[1];
            b_zero <= (b == '0);
            neg_q  <= a_neg_c ^ b_neg_c;
            neg_r  <= a_neg_c;
            a_raw  <= a;
            opnd_b <= b_mag_c;
            acc_hi <= '0;
            acc_lo <= a_mag_c;
         end
         if (iter_c) begin
            count <= count + CW'(1);
            if (is_div) begin
               acc_hi <= div_ge_c ? div_diff_c : div_shift_c[WIDTH-1:0];
               acc_lo <= {acc_lo[WIDTH-2:0], div_ge_c};
            end else begin
               acc_hi <= mul_sum_c[WIDTH:1];
               acc_lo <= {mul_sum_c[0], acc_lo[WIDTH-1:1]};
            end
         end
         if (commit_c) begin
            hi          <= res_hi_c;
            lo          <= res_lo_c;
            div_by_zero <= is_div && b_zero;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_sequencer;
   localparam int unsigned W = 32;
   localparam int unsigned LAT = W + 1;

   logic         clock = 1'b0;
   logic         clear_n, start_valid, start_ready, cancel, busy, done, div_by_zero;
   logic [1:0]   op;
   logic [W-1:0] a, b, hi, lo;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      int           acc_cyc;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    done_cyc[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   exp_t  mon_e;
   string mon_nm;

   muldiv_sequencer #(.WIDTH(W)) dut (
      .clock(clock), .clear_n(clear_n), .start_valid(start_valid),
      .start_ready(start_ready), .op(op), .a(a), .b(b), .cancel(cancel),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   // Monitor: every done must match the oldest outstanding expectation
   always @(negedge clock) begin
      if (clear_n && done) begin
         done_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 required=0");
         end else begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            check({mon_nm, "_hi"}, hi, mon_e.hi);
            check({mon_nm, "_lo"}, lo, mon_e.lo);
            check({mon_nm, "_dbz"}, W'(div_by_zero), W'(mon_e.dbz));
            check({mon_nm, "_latency"}, W'(cyc - mon_e.acc_cyc), W'(LAT));
         end
      end
   end

   task automatic issue(input string nm, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] eh,
                        input logic [W-1:0] el, input logic ed, input bit track);
      bit   got;
      exp_t e;
      got = 1'b0;
      @(negedge clock);
      start_valid = 1'b1;
      op = o;
      a  = x;
      b  = y;
      #1;
      for (int i = 0; i < 200; i++) begin
         if (start_ready) begin
            got = 1'b1;
            break;
         end
         @(negedge clock);
         #1;
      end
      if (got) begin
         @(posedge clock);
         #1;
         if (track) begin
            e.hi = eh;
            e.lo = el;
            e.dbz = ed;
            e.acc_cyc = cyc;
            exp_q.push_back(e);
            name_q.push_back(nm);
         end
      end else begin
         checks++;
         errors++;
         $display("FAIL %s_accept_timeout actual=0 required=1", nm);
      end
      start_valid = 1'b0;
      // Scramble operands after accept; they must not affect the result
      a  = $urandom;
      b  = $urandom;
      op = 2'($urandom);
   endtask

   task automatic wait_idle(input string nm);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         if (exp_q.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s_done_timeout actual=%0d required=0", nm, exp_q.size());
      end
   endtask

   task automatic check_reset_state(input string nm);
      check({nm, "_hi"}, hi, '0);
      check({nm, "_lo"}, lo, '0);
      check({nm, "_busy"}, W'(busy), '0);
      check({nm, "_done"}, W'(done), '0);
      check({nm, "_dbz"}, W'(div_by_zero), '0);
      check({nm, "_ready"}, W'(start_ready), '0);
   endtask

   initial begin
      int n0;
      clear_n = 1'b0;
      start_valid = 1'b0;
      cancel = 1'b0;
      op = 2'b00;
      a = '0;
      b = '0;
      #3;
      check_reset_state("reset");
      #20;
      @(negedge clock);
      clear_n = 1'b1;

      issue("muls_m3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1);
      wait_idle("t1");
      issue("mulu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1);
      issue("muls_m1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0, 1'b1);
      issue("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
      issue("divs_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1);
      issue("divs_7_m2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b1);
      issue("divu_5_0", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b1);
      issue("divs_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b1);
      issue("divs_m5_0", 2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1'b1);
      wait_idle("t2_4");

      // cancel while idle blocks accept
      @(negedge clock);
      cancel = 1'b1;
      start_valid = 1'b1;
      #1;
      check("idle_cancel_ready", W'(start_ready), '0);
      @(posedge clock);
      #1;
      check("idle_cancel_busy", W'(busy), '0);
      cancel = 1'b0;
      start_valid = 1'b0;

      // cancel mid-RUN
      issue("cancel_run", 2'b10, 32'd50, 32'd3, '0, '0, 1'b0, 1'b0);
      repeat (10) @(negedge clock);
      cancel = 1'b1;
      @(posedge clock);
      #1;
      cancel = 1'b0;
      check("cancel_run_busy", W'(busy), '0);
      repeat (40) @(negedge clock);
      check("cancel_run_hi", hi, 32'hFFFF_FFFB);
      check("cancel_run_lo", lo, 32'hFFFF_FFFF);
      check("cancel_run_dbz", W'(div_by_zero), 32'd1);

      // cancel coinciding with the final FIX edge
      issue("cancel_fix", 2'b01, 32'd9, 32'd9, '0, '0, 1'b0, 1'b0);
      repeat (W) @(posedge clock);
      #1;
      cancel = 1'b1;
      @(posedge clock);
      #1;
      cancel = 1'b0;
      check("cancel_fix_busy", W'(busy), '0);
      repeat (10) @(negedge clock);
      check("cancel_fix_hi", hi, 32'hFFFF_FFFB);

      // back-to-back: second request held valid through the done cycle
      n0 = done_cyc.size();
      issue("b2b_mul", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b1);
      issue("b2b_div", 2'b10, 32'd100, 32'd10, 32'd0, 32'd10, 1'b0, 1'b1);
      wait_idle("b2b");
      if (done_cyc.size() >= n0 + 2)
         check("b2b_spacing", W'(done_cyc[n0+1] - done_cyc[n0]), W'(W + 2));
      else begin
         checks++;
         errors++;
         $display("FAIL b2b_spacing actual=%0d dones required=2", done_cyc.size() - n0);
      end

      // async reset mid-RUN after leaving div_by_zero set
      issue("divu_9_0", 2'b10, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1'b1, 1'b1);
      wait_idle("t6_pre");
      issue("reset_run", 2'b01, 32'd1234, 32'd5678, '0, '0, 1'b0, 1'b0);
      repeat (5) @(posedge clock);
      #2;
      clear_n = 1'b0;
      #1;
      check_reset_state("midrun_reset");
      exp_q.delete();
      name_q.delete();
      @(negedge clock);
      clear_n = 1'b1;
      issue("mulu_3x4", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b1);
      wait_idle("t6");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
